// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared between the fetch stage and the main control decoder.
//   fetch_state_e  fetch FSM states (request, wait for data, hold skid word)
//   NOP_INSTR      instruction word placed in IF/ID for bubbles/flushes
//   OP_*           6-bit primary opcodes decoded from if_id_instr[31:26]
package mips_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  typedef logic [5:0] opcode_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam opcode_t OP_LW   = 6'b000011;
  localparam opcode_t OP_SW   = 6'b001011;
  localparam opcode_t OP_BEQ  = 6'b110100;
  localparam opcode_t OP_BNE  = 6'b110101;
  localparam opcode_t OP_JUMP = 6'b010010;

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {instr, pc4} holding buffer used when a fetched word
// returns while the IF/ID register is stalled.
//   clk, rst         clock, synchronous active-high reset
//   load             capture instr_in/pc4_in, mark full
//   drain            mark empty (contents moved to IF/ID)
//   clear            discard contents (redirect); wins over load/drain
//   instr_in, pc4_in word and PC+4 to capture
//   valid            buffer holds a word
//   instr, pc4       buffered word and its PC+4
module fetch_skid_buf #(
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          drain,
  input  logic          clear,
  input  logic [31:0]   instr_in,
  input  logic [AW-1:0] pc4_in,
  output logic          valid,
  output logic [31:0]   instr,
  output logic [AW-1:0] pc4
);

  logic          valid_q, valid_d;
  logic [31:0]   instr_q, instr_d;
  logic [AW-1:0] pc4_q,   pc4_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = instr_in;
      pc4_d   = pc4_in;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc4   = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the PC, issues single outstanding
// requests to instruction memory (req/gnt/rvalid), and fills the IF/ID register.
//   clk, rst                    clock, synchronous active-high reset
//   stall                       IF/ID must hold this cycle
//   branch_taken/branch_target  taken branch redirect (wins over jump)
//   jump/jump_target            jump redirect
//   imem_req/imem_addr          fetch request and word-aligned address
//   imem_gnt                    request accepted (with imem_req)
//   imem_rvalid/imem_rdata      returned instruction word
//   pc                          current fetch PC
//   if_id_valid/instr/pc4       IF/ID pipeline register
module fetch_stage #(
  parameter int unsigned    AW        = 32,
  parameter logic [AW-1:0]  RESET_PC  = '0,
  parameter logic [31:0]    NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target,
  input  logic          jump,
  input  logic [AW-1:0] jump_target,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  output logic [AW-1:0] pc,
  output logic          if_id_valid,
  output logic [31:0]   if_id_instr,
  output logic [AW-1:0] if_id_pc4
);

  import mips_pkg::*;

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          drop_q, drop_d;
  logic          req_q, req_d;
  logic          ifv_q, ifv_d;
  logic [31:0]   ifi_q, ifi_d;
  logic [AW-1:0] ifp_q, ifp_d;

  logic          redirect;
  logic [AW-1:0] redirect_target;
  logic [AW-1:0] pc_plus4;
  logic          handshake;

  logic          skid_load, skid_drain, skid_clear;
  logic          skid_valid;
  logic [31:0]   skid_instr;
  logic [AW-1:0] skid_pc4;

  assign redirect        = branch_taken | jump;
  assign redirect_target = branch_taken ? branch_target : jump_target;
  assign pc_plus4        = pc_q + AW'(4);
  // req_q is only ever set while in S_REQ
  assign handshake       = req_q & imem_gnt;

  fetch_skid_buf #(.AW(AW)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .drain    (skid_drain),
    .clear    (skid_clear),
    .instr_in (imem_rdata),
    .pc4_in   (pc_plus4),
    .valid    (skid_valid),
    .instr    (skid_instr),
    .pc4      (skid_pc4)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    ifv_d      = ifv_q;
    ifi_d      = ifi_q;
    ifp_d      = ifp_q;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    skid_clear = 1'b0;

    // No new word: stall holds IF/ID, otherwise a bubble with pc4 kept.
    if (!stall) begin
      ifv_d = 1'b0;
      ifi_d = NOP_INSTR;
    end

    unique case (state_q)
      S_REQ: begin
        if (handshake) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
          drop_d  = 1'b0;
          if (!drop_q && !redirect) begin
            pc_d = pc_plus4;
            if (stall) begin
              skid_load = 1'b1;
              state_d   = S_HOLD;
            end else begin
              ifv_d = 1'b1;
              ifi_d = imem_rdata;
              ifp_d = pc_plus4;
            end
          end
        end
      end
      S_HOLD: begin
        if (!stall && skid_valid) begin
          ifv_d      = 1'b1;
          ifi_d      = skid_instr;
          ifp_d      = skid_pc4;
          skid_drain = 1'b1;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // Redirect is applied last so it overrides stall and any load above.
    if (redirect) begin
      pc_d       = redirect_target;
      ifv_d      = 1'b0;
      ifi_d      = NOP_INSTR;
      ifp_d      = ifp_q;
      skid_clear = 1'b1;
      case (state_q)
        S_REQ:   drop_d = handshake;
        S_WAIT:  if (!imem_rvalid) drop_d = 1'b1;
        S_HOLD:  state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end

    req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      req_q   <= 1'b0;
      ifv_q   <= 1'b0;
      ifi_q   <= NOP_INSTR;
      ifp_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      req_q   <= req_d;
      ifv_q   <= ifv_d;
      ifi_q   <= ifi_d;
      ifp_q   <= ifp_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = {pc_q[AW-1:2], 2'b00};
  assign pc          = pc_q;
  assign if_id_valid = ifv_q;
  assign if_id_instr = ifi_q;
  assign if_id_pc4   = ifp_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, jump, imem_gnt, imem_rvalid;
  logic [31:0] branch_target, jump_target, imem_rdata;

  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, pc, if_id_instr, if_id_pc4;
  logic        imem_req2, if_id_valid2;
  logic [31:0] imem_addr2, pc2, if_id_instr2, if_id_pc42;

  always #5 clk = ~clk;

  fetch_stage #(.AW(32), .RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc(pc), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4)
  );

  fetch_stage #(.AW(32), .RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut_wrap (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc(pc2), .if_id_valid(if_id_valid2), .if_id_instr(if_id_instr2), .if_id_pc4(if_id_pc42)
  );

  int total = 0;
  int bad   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] word_at(logic [31:0] a);
    return 32'h2001_0005 + a;
  endfunction

  // ---------------- memory responder ----------------
  bit          pend = 0;
  int          cnt  = 0;
  int          lat  = 1;
  logic [31:0] pend_addr;

  task automatic tick();
    logic        hs;
    logic [31:0] a;
    hs = imem_req & imem_gnt;
    a  = imem_addr;
    @(posedge clk); #2;
    imem_rvalid = 1'b0;
    if (hs === 1'b1) begin
      pend = 1; pend_addr = a; cnt = lat;
    end
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        pend = 0;
        imem_rvalid = 1'b1;
        imem_rdata  = word_at(pend_addr);
      end
    end
  endtask

  // ---------------- behavioural model ----------------
  // Fetch is described as transactions: a queue of accepted, unanswered
  // requests (with a stale mark) and a queue of words waiting for IF/ID.
  bit          m_ready = 0;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_req;
  logic [31:0] addrq[$];
  bit          staleq[$];
  logic [31:0] held_instr[$];
  logic [31:0] held_pc4[$];
  bit          m_redirect, m_deliver, m_stale_rsp;
  logic [31:0] m_tgt, m_rsp_addr;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 32'h0; m_valid = 0; m_instr = NOP; m_pc4 = 0; m_req = 0;
      addrq.delete(); staleq.delete(); held_instr.delete(); held_pc4.delete();
      m_ready = 1;
    end else if (m_ready) begin
      m_redirect = branch_taken || jump;
      m_tgt      = branch_taken ? branch_target : jump_target;
      m_deliver  = 0;
      m_rsp_addr = 0;
      if (imem_rvalid && addrq.size() != 0) begin
        m_rsp_addr  = addrq.pop_front();
        m_stale_rsp = staleq.pop_front();
        m_deliver   = !m_stale_rsp && !m_redirect;
      end
      if (m_redirect && staleq.size() != 0) staleq[0] = 1;
      if (m_req && imem_gnt) begin
        addrq.push_back(m_pc);
        staleq.push_back(m_redirect);
      end
      if (m_redirect) begin
        m_pc = m_tgt; m_valid = 0; m_instr = NOP;
        held_instr.delete(); held_pc4.delete();
      end else if (m_deliver) begin
        m_pc = m_rsp_addr + 4;
        if (stall) begin
          held_instr.push_back(imem_rdata);
          held_pc4.push_back(m_rsp_addr + 4);
        end else begin
          m_valid = 1; m_instr = imem_rdata; m_pc4 = m_rsp_addr + 4;
        end
      end else if (!stall) begin
        if (held_instr.size() != 0) begin
          m_valid = 1; m_instr = held_instr.pop_front(); m_pc4 = held_pc4.pop_front();
        end else begin
          m_valid = 0; m_instr = NOP;
        end
      end
      m_req = (addrq.size() == 0) && (held_instr.size() == 0);
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      check("cmp_req",   {31'b0, imem_req},    {31'b0, m_req});
      check("cmp_addr",  imem_addr,            {m_pc[31:2], 2'b00});
      check("cmp_pc",    pc,                   m_pc);
      check("cmp_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
      check("cmp_instr", if_id_instr,          m_instr);
      check("cmp_pc4",   if_id_pc4,            m_pc4);
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1; stall = 0; branch_taken = 0; jump = 0; imem_gnt = 0;
    imem_rvalid = 0; imem_rdata = 0; branch_target = 0; jump_target = 0;
    tick(); tick();
    rst = 0;
    // reset state
    check("rst_req",   {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, if_id_valid}, 32'd0);
    check("rst_instr", if_id_instr, NOP);
    check("rst_pc4",   if_id_pc4, 32'd0);
    check("rst_pc",    pc, 32'd0);
    check("wrap_rst_pc", pc2, 32'hFFFF_FFFC);

    // 1: straight-line fetch
    imem_gnt = 1; lat = 1;
    tick();
    check("t1_req",  {31'b0, imem_req}, 32'd1);
    check("t1_addr0", imem_addr, 32'h0);
    check("wrap_addr", imem_addr2, 32'hFFFF_FFFC);
    check("wrap_req", {31'b0, imem_req2}, 32'd1);
    tick(); tick();
    check("t1_instr", if_id_instr, 32'h2001_0005);
    check("t1_pc4",   if_id_pc4, 32'd4);
    check("t1_valid", {31'b0, if_id_valid}, 32'd1);
    check("t1_addr4", imem_addr, 32'd4);
    // 5: RESET_PC at top of address space wraps
    check("wrap_pc",    pc2, 32'h0);
    check("wrap_pc4",   if_id_pc42, 32'h0);
    check("wrap_valid", {31'b0, if_id_valid2}, 32'd1);
    check("wrap_instr", if_id_instr2, 32'h2001_0005);
    tick(); tick();
    check("t1_addr8",  imem_addr, 32'd8);
    check("t1_instr2", if_id_instr, 32'h2001_0009);

    // 2: response during a 3-cycle stall goes to the skid buffer
    stall = 1;
    tick(); tick();
    check("t2_req_hold", {31'b0, imem_req}, 32'd0);
    check("t2_instr_hold", if_id_instr, 32'h2001_0009);
    check("t2_pc", pc, 32'd12);
    tick();
    stall = 0;
    tick();
    check("t2_skid_instr", if_id_instr, 32'h2001_000D);
    check("t2_skid_pc4",   if_id_pc4, 32'd12);
    check("t2_next_addr",  imem_addr, 32'd12);

    // 3: branch while waiting; late response discarded
    lat = 3;
    tick();
    branch_taken = 1; branch_target = 32'h40;
    tick();
    branch_taken = 0;
    check("t3_pc", pc, 32'h40);
    tick(); tick();
    check("t3_addr",  imem_addr, 32'h40);
    check("t3_valid", {31'b0, if_id_valid}, 32'd0);
    check("t3_instr", if_id_instr, NOP);

    // 4: branch and jump together under stall, request accepted same cycle
    lat = 1;
    tick(); tick();
    check("t4_pre_instr", if_id_instr, 32'h2001_0045);
    branch_taken = 1; branch_target = 32'h80;
    jump = 1; jump_target = 32'h100; stall = 1;
    tick();
    branch_taken = 0; jump = 0; stall = 0;
    check("t4_pc",    pc, 32'h80);
    check("t4_valid", {31'b0, if_id_valid}, 32'd0);
    check("t4_pc4",   if_id_pc4, 32'h44);
    tick();
    check("t4_addr", imem_addr, 32'h80);
    tick(); tick();
    check("t4_instr", if_id_instr, 32'h2001_0085);

    // unaligned jump target: pc verbatim, address masked
    imem_gnt = 0;
    jump = 1; jump_target = 32'h103;
    tick();
    jump = 0;
    check("ua_pc",   pc, 32'h103);
    check("ua_addr", imem_addr, 32'h100);

    // stray rvalid with nothing outstanding
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    check("stray_valid", {31'b0, if_id_valid}, 32'd0);

    // 6: reset in S_WAIT, response arrives after reset
    imem_gnt = 1; lat = 2;
    tick();
    rst = 1;
    tick();
    rst = 0;
    check("t6_req",   {31'b0, imem_req}, 32'd0);
    check("t6_pc",    pc, 32'h0);
    check("t6_instr", if_id_instr, NOP);
    tick();
    check("t6_req2",  {31'b0, imem_req}, 32'd1);
    check("t6_addr",  imem_addr, 32'h0);
    check("t6_valid", {31'b0, if_id_valid}, 32'd0);

    // mixed traffic checked by the model
    for (int i = 0; i < 300; i++) begin
      stall        = ($urandom_range(0, 9) < 3);
      imem_gnt     = ($urandom_range(0, 9) < 7);
      branch_taken = ($urandom_range(0, 19) == 0);
      jump         = ($urandom_range(0, 19) == 0);
      branch_target = $urandom & 32'h0000_0FFF;
      jump_target   = $urandom & 32'h0000_0FFF;
      lat           = $urandom_range(1, 3);
      tick();
    end
    stall = 0; branch_taken = 0; jump = 0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
